// File: rtl/weight_loader.sv
// ---------------------------------------------------------------------------
// weight_loader
//
// Purpose
//   Drives the shared weight-write bus of the PE array. Packed weight beats
//   arrive on a valid/ready stream. Each beat is unpacked and written out one
//   weight per cycle to PE addresses 0..NUM_PE-1 in order. Every PE latches
//   the write whose address matches its own. A one-cycle o_done pulse tells
//   the conv controller that the whole weight set has been loaded.
//
// Parameters
//   WEIGHT_BW  signed weight width, same as the PE weight width
//   ADDR_BW    PE address width, NUM_PE <= 2**ADDR_BW
//   NUM_PE     weights per load (one per PE), >= 1
//   PACK       weights per input beat, >= 1
//
// Ports
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   i_start      in   begin a load; only honoured in IDLE
//   i_abort      in   synchronous abort; returns to IDLE from any state
//   s_valid      in   input beat valid
//   s_ready      out  input beat ready
//   s_data       in   packed weights, lane k = [k*WEIGHT_BW +: WEIGHT_BW]
//   o_w_en       out  weight write strobe (registered)
//   o_addr       out  target PE address (registered)
//   o_w          out  weight value, raw bits (registered)
//   o_busy       out  high in every state except IDLE
//   o_done       out  one-cycle pulse when a load completes (registered)
//   o_dbg_state  out  current FSM state, for observation only
//
// Handshake: a beat transfers on any rising edge where s_valid and s_ready
// are both high. s_ready depends only on the FSM state and i_abort, never on
// s_valid, so the source may present or withdraw data freely while s_valid
// is low. Once s_valid is raised the source holds s_data until the transfer.
// ---------------------------------------------------------------------------
module weight_loader #(
  parameter int WEIGHT_BW = 8,
  parameter int ADDR_BW   = 5,
  parameter int NUM_PE    = 9,
  parameter int PACK      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [PACK*WEIGHT_BW-1:0] s_data,
  output logic                      o_w_en,
  output logic [ADDR_BW-1:0]        o_addr,
  output logic [WEIGHT_BW-1:0]      o_w,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [1:0]                o_dbg_state
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int LANE_BW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int BEAT_W  = PACK * WEIGHT_BW;

  localparam logic [ADDR_BW-1:0] LAST_ADDR = ADDR_BW'(NUM_PE - 1);
  localparam logic [LANE_BW-1:0] LAST_LANE = LANE_BW'(PACK - 1);

  // State and counters
  logic [1:0]           state_q, state_d;
  logic [ADDR_BW-1:0]   addr_q,  addr_d;
  logic [LANE_BW-1:0]   lane_q,  lane_d;
  logic [BEAT_W-1:0]    hold_q,  hold_d;

  // Registered outputs
  logic                 w_en_q,  w_en_d;
  logic [ADDR_BW-1:0]   waddr_q, waddr_d;
  logic [WEIGHT_BW-1:0] w_q,     w_d;
  logic                 done_q,  done_d;

  logic                 handshake;
  logic                 last_write;
  logic [WEIGHT_BW-1:0] held_w;

  // Ready is withdrawn in the abort cycle so an aborted load never swallows
  // a beat the source would otherwise consider delivered.
  assign s_ready   = (state_q == ST_FETCH) && !i_abort;
  assign handshake = s_valid && s_ready;

  // The write being issued this edge targets the final PE.
  assign last_write = (addr_q == LAST_ADDR);

  // Select the held lane addressed by the lane counter. The whole beat is
  // kept in the holding register, lane 0 included, so the lane counter can
  // index it directly without an offset.
  always_comb begin
    held_w = '0;
    for (int k = 0; k < PACK; k++) begin
      if (lane_q == LANE_BW'(k)) begin
        held_w = hold_q[k*WEIGHT_BW +: WEIGHT_BW];
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lane_d  = lane_q;
    hold_d  = hold_q;
    w_en_d  = 1'b0;
    waddr_d = waddr_q;   // address and data hold while the strobe is low
    w_d     = w_q;
    done_d  = 1'b0;

    if (i_abort) begin
      // Abort wins over everything: no write, no done, counters cleared.
      state_d = ST_IDLE;
      addr_d  = '0;
      lane_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_d = ST_FETCH;
            addr_d  = '0;
            lane_d  = '0;
          end
        end

        ST_FETCH: begin
          if (handshake) begin
            // Lane 0 goes straight to the bus on the accepting edge.
            w_en_d  = 1'b1;
            waddr_d = addr_q;
            w_d     = s_data[WEIGHT_BW-1:0];
            hold_d  = s_data;
            lane_d  = LANE_BW'(1);
            addr_d  = addr_q + ADDR_BW'(1);
            if (last_write) begin
              state_d = ST_DONE;
            end else if (PACK > 1) begin
              state_d = ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          w_en_d  = 1'b1;
          waddr_d = addr_q;
          w_d     = held_w;
          addr_d  = addr_q + ADDR_BW'(1);
          lane_d  = lane_q + LANE_BW'(1);
          if (last_write) begin
            // Any lanes left in the held beat are dropped.
            state_d = ST_DONE;
          end else if (lane_q == LAST_LANE) begin
            state_d = ST_FETCH;
          end
        end

        ST_DONE: begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          addr_d  = '0;
          lane_d  = '0;
        end

        default: begin
          state_d = ST_IDLE;
          addr_d  = '0;
          lane_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      lane_q  <= '0;
      hold_q  <= '0;
      w_en_q  <= 1'b0;
      waddr_q <= '0;
      w_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lane_q  <= lane_d;
      hold_q  <= hold_d;
      w_en_q  <= w_en_d;
      waddr_q <= waddr_d;
      w_q     <= w_d;
      done_q  <= done_d;
    end
  end

  assign o_w_en      = w_en_q;
  assign o_addr      = waddr_q;
  assign o_w         = w_q;
  assign o_done      = done_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_weight_loader.sv
module tb_weight_loader;

  localparam int WEIGHT_BW = 8;
  localparam int ADDR_BW   = 5;
  localparam int NUM_PE    = 9;
  localparam int PACK      = 4;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                      i_start, i_abort, s_valid, s_ready;
  logic [PACK*WEIGHT_BW-1:0] s_data;
  logic                      o_w_en, o_busy, o_done;
  logic [ADDR_BW-1:0]        o_addr;
  logic [WEIGHT_BW-1:0]      o_w;
  logic [1:0]                o_dbg_state;

  weight_loader #(
    .WEIGHT_BW(WEIGHT_BW), .ADDR_BW(ADDR_BW), .NUM_PE(NUM_PE), .PACK(PACK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .o_w_en(o_w_en), .o_addr(o_addr), .o_w(o_w), .o_busy(o_busy),
    .o_done(o_done), .o_dbg_state(o_dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: a loader is a list of weights still owed to the bus.
  // While busy it writes one owed weight per cycle; when nothing is owed it
  // asks for a beat and writes lane 0 of it on the accepting edge. After the
  // NUM_PE-th write it idles one cycle and then pulses done.
  // ---------------------------------------------------------------------
  logic [WEIGHT_BW-1:0] pend_q[$];
  logic                 m_busy = 1'b0;
  logic                 m_fin  = 1'b0;
  int                   m_next = 0;
  logic                 e_we = 1'b0, e_done = 1'b0;
  logic [ADDR_BW-1:0]   e_addr = '0;
  logic [WEIGHT_BW-1:0] e_w = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q.delete();
      m_busy = 1'b0; m_fin = 1'b0; m_next = 0;
      e_we = 1'b0; e_done = 1'b0; e_addr = '0; e_w = '0;
    end else begin
      e_we = 1'b0;
      e_done = 1'b0;
      if (i_abort) begin
        m_busy = 1'b0; m_fin = 1'b0; pend_q.delete();
      end else if (!m_busy) begin
        if (i_start) begin
          m_busy = 1'b1; m_next = 0;
        end
      end else if (m_fin) begin
        m_busy = 1'b0; m_fin = 1'b0; e_done = 1'b1;
      end else begin
        if (pend_q.size() == 0 && s_valid) begin
          for (int k = 0; k < PACK; k++)
            pend_q.push_back(s_data[k*WEIGHT_BW +: WEIGHT_BW]);
        end
        if (pend_q.size() > 0) begin
          e_we   = 1'b1;
          e_addr = ADDR_BW'(m_next);
          e_w    = pend_q.pop_front();
          m_next++;
          if (m_next == NUM_PE) begin
            m_fin = 1'b1;
            pend_q.delete();
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Scoreboard / monitor: compare every cycle, log writes for literal pins.
  // ---------------------------------------------------------------------
  logic signed [WEIGHT_BW-1:0] wr_log [0:31];
  int wr_cnt = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    #2;
    chk("w_en", 32'(o_w_en), 32'(e_we));
    chk("addr", 32'(o_addr), 32'(e_addr));
    chk("w", 32'(o_w), 32'(e_w));
    chk("done", 32'(o_done), 32'(e_done));
    chk("busy", 32'(o_busy), 32'(m_busy));
    chk("s_ready", 32'(s_ready),
        32'(m_busy && !m_fin && pend_q.size() == 0 && !i_abort));
    if (o_w_en) begin
      wr_log[o_addr] = o_w;
      wr_cnt++;
    end
    if (o_done) done_cnt++;
  end

  // ---------------------------------------------------------------------
  // Driver tasks (all start and end just after a falling edge)
  // ---------------------------------------------------------------------
  task automatic clear_log();
    for (int i = 0; i < 32; i++) wr_log[i] = '0;
    wr_cnt = 0;
  endtask

  task automatic start_load();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Presents a beat and leaves s_valid high after the accepting edge.
  task automatic beat(input logic [PACK*WEIGHT_BW-1:0] d);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    forever begin
      #1;
      if (s_ready) break;
      n++;
      if (n > 50) begin
        chk("beat_accept_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic wait_done_cnt(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 32'(done_cnt >= target), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic pin_seq_1_to_9(input string nm);
    for (int i = 0; i < NUM_PE; i++) chk(nm, 32'(wr_log[i]), i + 1);
    chk({nm, "_cnt"}, wr_cnt, NUM_PE);
  endtask

  // Full load with s_valid held high, then an extra beat that must be refused.
  task automatic load_std();
    start_load();
    beat(32'h04030201);
    beat(32'h08070605);
    beat(32'hAABBCC09);
    s_data = 32'h5A5A5A5A;   // extra beat stays with the source
    repeat (4) @(negedge clk);
    s_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  int d0;

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; s_valid = 1'b0; s_data = '0;
    clear_log();
    #12;
    chk("rst_w_en", 32'(o_w_en), 0);
    chk("rst_addr", 32'(o_addr), 0);
    chk("rst_w", 32'(o_w), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_ready", 32'(s_ready), 0);
    #10 rst_n = 1'b1;
    @(negedge clk);

    // 1: basic load
    clear_log(); d0 = done_cnt;
    load_std();
    wait_done_cnt(d0 + 1);
    pin_seq_1_to_9("s1_w");
    chk("s1_done_once", done_cnt - d0, 1);

    // 2: backpressure gap after beat 1
    clear_log(); d0 = done_cnt;
    start_load();
    beat(32'h04030201);
    s_valid = 1'b0; s_data = 32'hDEADBEEF;
    repeat (5) @(negedge clk);
    chk("s2_busy_gap", 32'(o_busy), 1);
    beat(32'h08070605);
    beat(32'hAABBCC09);
    s_valid = 1'b0;
    wait_done_cnt(d0 + 1);
    pin_seq_1_to_9("s2_w");

    // 3: signed pass-through
    clear_log(); d0 = done_cnt;
    start_load();
    beat(32'h007FFF80);
    beat(32'h11223344);
    beat(32'h00000055);
    s_valid = 1'b0;
    wait_done_cnt(d0 + 1);
    chk("s3_w0", 32'(wr_log[0]), -128);
    chk("s3_w1", 32'(wr_log[1]), -1);
    chk("s3_w2", 32'(wr_log[2]), 127);
    chk("s3_w3", 32'(wr_log[3]), 0);
    chk("s3_w8", 32'(wr_log[8]), 32'sh55);

    // 4: abort in ISSUE once addr 5 is on the bus
    clear_log(); d0 = done_cnt;
    start_load();
    beat(32'h04030201);
    beat(32'h08070605);   // addr 4 now on the bus
    s_valid = 1'b0;
    @(negedge clk);       // addr 5 now on the bus
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    #2;
    chk("s4_busy", 32'(o_busy), 0);
    chk("s4_w_en", 32'(o_w_en), 0);
    chk("s4_writes", wr_cnt, 6);
    repeat (3) @(negedge clk);
    chk("s4_no_done", done_cnt - d0, 0);
    clear_log(); d0 = done_cnt;
    load_std();
    wait_done_cnt(d0 + 1);
    pin_seq_1_to_9("s4_reload_w");

    // 5: i_start pulses while busy
    clear_log(); d0 = done_cnt;
    start_load();
    i_start = 1'b1;       // in FETCH, no beat offered yet
    @(negedge clk);
    i_start = 1'b0;
    beat(32'h04030201);
    s_valid = 1'b0;
    i_start = 1'b1;       // in ISSUE
    @(negedge clk);
    i_start = 1'b0;
    beat(32'h08070605);
    beat(32'hAABBCC09);
    s_valid = 1'b0;
    wait_done_cnt(d0 + 1);
    repeat (4) @(negedge clk);
    pin_seq_1_to_9("s5_w");
    chk("s5_done_once", done_cnt - d0, 1);

    // 6: asynchronous reset during ISSUE
    clear_log(); d0 = done_cnt;
    start_load();
    beat(32'h04030201);
    #3 rst_n = 1'b0;
    #1;
    chk("s6_w_en", 32'(o_w_en), 0);
    chk("s6_done", 32'(o_done), 0);
    chk("s6_addr", 32'(o_addr), 0);
    chk("s6_busy", 32'(o_busy), 0);
    s_valid = 1'b0;
    #23 rst_n = 1'b1;
    @(negedge clk);
    clear_log(); d0 = done_cnt;
    load_std();
    wait_done_cnt(d0 + 1);
    pin_seq_1_to_9("s6_w");

    // start and abort together in IDLE
    i_start = 1'b1; i_abort = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_abort = 1'b0;
    #2;
    chk("idle_start_abort_busy", 32'(o_busy), 0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
